mux_sel_arbiter: RTL and testbench

Round-robin arbiter that generates the one-hot `sel1`/`sel2`/`sel3` selects for the 3-input registered mux. It sits directly upstream of the mux. Three requesters compete for the mux output. Each grant lasts a bounded number of cycles, and grants are separated by a one-cycle all-zero gap, so the selects are never multi-hot.

---
 rtl/mux_sel_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter producing one-hot registered selects
// (sel1/sel2/sel3) for a 3-input registered mux. Grants last at most
// HOLD_CYCLES cycles and are separated by a one-cycle all-zero gap that
// carries a done pulse.
//
// Optional feature macro: MUX_ARB_LOCK_EN
//   Adds a lock input. While lock is high and the granted request is still
//   asserted, the HOLD_CYCLES expiry is suppressed and the hold counter
//   saturates at HOLD_CYCLES-1.
module mux_sel_arbiter #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [2:0] req,
`ifdef MUX_ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic       sel1,
   output logic       sel2,
   output logic       sel3,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       done
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   // Last count value of a grant; the counter is 4 bits wide.
   localparam logic [3:0] LP_LIMIT = 4'(HOLD_CYCLES - 1);

   state_e     r_state;
   state_e     w_state_d;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_d;
   // Index (0..2) of the most recent grant; also the owner while in StGrant.
   logic [1:0] r_last;
   logic [1:0] w_last_d;
   logic [2:0] r_sel;
   logic [2:0] w_sel_d;
   logic [1:0] r_gnt;
   logic [1:0] w_gnt_d;
   logic       r_done;
   logic       w_done_d;

   logic       w_pick_valid;
   logic [1:0] w_pick_idx;
   logic       w_gnt_req;
   logic       w_at_limit;
   logic       w_expire;
   logic       w_end;

   // Round-robin pick: search last+1, last+2, last+3 (mod 3).
   always_comb begin
      w_pick_valid = |req;
      w_pick_idx   = 2'd0;
      case (r_last)
         2'd0: begin
            if (req[1])      w_pick_idx = 2'd1;
            else if (req[2]) w_pick_idx = 2'd2;
            else             w_pick_idx = 2'd0;
         end
         2'd1: begin
            if (req[2])      w_pick_idx = 2'd2;
            else if (req[0]) w_pick_idx = 2'd0;
            else             w_pick_idx = 2'd1;
         end
         default: begin
            if (req[0])      w_pick_idx = 2'd0;
            else if (req[1]) w_pick_idx = 2'd1;
            else             w_pick_idx = 2'd2;
         end
      endcase
   end

   // Request bit of the current owner, plus grant-termination conditions.
   always_comb begin
      case (r_last)
         2'd0:    w_gnt_req = req[0];
         2'd1:    w_gnt_req = req[1];
         default: w_gnt_req = req[2];
      endcase
      w_at_limit = (r_cnt == LP_LIMIT);
`ifdef MUX_ARB_LOCK_EN
      // Lock only holds the grant while the owner still requests.
      w_expire   = w_at_limit && !lock;
`else
      w_expire   = w_at_limit;
`endif
      w_end      = !w_gnt_req || w_expire;
   end

   // Next-state and next-output logic for the IDLE/GRANT FSM.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_last_d  = r_last;
      w_sel_d   = r_sel;
      w_gnt_d   = r_gnt;
      w_done_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_sel_d = 3'b000;
            w_gnt_d = 2'd0;
            if (w_pick_valid) begin
               w_state_d = StGrant;
               w_sel_d   = 3'b001 << w_pick_idx;
               w_gnt_d   = w_pick_idx + 2'd1;
               w_cnt_d   = 4'd0;
               w_last_d  = w_pick_idx;
            end
         end
         StGrant: begin
            if (w_end) begin
               // A drop coinciding with expiry still ends the grant once.
               w_state_d = StIdle;
               w_sel_d   = 3'b000;
               w_gnt_d   = 2'd0;
               w_cnt_d   = 4'd0;
               w_done_d  = 1'b1;
            end else if (!w_at_limit) begin
               w_cnt_d = r_cnt + 4'd1;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_sel_d   = 3'b000;
            w_gnt_d   = 2'd0;
            w_cnt_d   = 4'd0;
         end
      endcase
   end

   // State and registered outputs; reset points at requester 3 so
   // requester 1 has first priority.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_last  <= 2'd2;
         r_sel   <= 3'b000;
         r_gnt   <= 2'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_last  <= w_last_d;
         r_sel   <= w_sel_d;
         r_gnt   <= w_gnt_d;
         r_done  <= w_done_d;
      end
   end

   assign sel1   = r_sel[0];
   assign sel2   = r_sel[1];
   assign sel3   = r_sel[2];
   assign gnt_id = r_gnt;
   assign busy   = (r_state == StGrant);
   assign done   = r_done;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Testbench for mux_sel_arbiter: behavioural reference model feeding a
// scoreboard queue, plus directed checks against hand-derived constants.
// Honours MUX_ARB_LOCK_EN when defined.
module tb_mux_sel_arbiter;

   localparam int HOLD = 4;

   logic       clock = 1'b0;
   logic       resetn;
   logic [2:0] req;
   logic       lock;
   logic       sel1, sel2, sel3, busy, done;
   logic [1:0] gnt_id;
   logic       h1_sel1, h1_sel2, h1_sel3, h1_busy, h1_done;
   logic [1:0] h1_gnt_id;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner 0 = none, held = cycles owned so far.
   int   m_owner;
   int   m_held;
   int   m_last;
   logic m_done;
   logic [6:0] sb_q[$];

   mux_sel_arbiter #(.HOLD_CYCLES(HOLD)) dut (
      .clock  (clock),
      .resetn (resetn),
      .req    (req),
`ifdef MUX_ARB_LOCK_EN
      .lock   (lock),
`endif
      .sel1   (sel1),
      .sel2   (sel2),
      .sel3   (sel3),
      .gnt_id (gnt_id),
      .busy   (busy),
      .done   (done)
   );

   // Second instance at the HOLD_CYCLES = 1 boundary.
   mux_sel_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
      .clock  (clock),
      .resetn (resetn),
      .req    (req),
`ifdef MUX_ARB_LOCK_EN
      .lock   (lock),
`endif
      .sel1   (h1_sel1),
      .sel2   (h1_sel2),
      .sel3   (h1_sel3),
      .gnt_id (h1_gnt_id),
      .busy   (h1_busy),
      .done   (h1_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] m_expect();
      logic [1:0] g;
      g = 2'(m_owner);
      return {m_owner == 3, m_owner == 2, m_owner == 1, g, m_owner != 0, m_done};
   endfunction

   task automatic m_reset();
      m_owner = 0;
      m_held  = 0;
      m_last  = 2;
      m_done  = 1'b0;
   endtask

   task automatic m_edge(input logic [2:0] r, input logic lk);
      int  idx;
      bit  found;
      logic lk_eff;
`ifdef MUX_ARB_LOCK_EN
      lk_eff = lk;
`else
      lk_eff = 1'b0;
`endif
      if (m_owner == 0) begin
         m_done = 1'b0;
         found  = 1'b0;
         for (int k = 1; k <= 3; k++) begin
            idx = (m_last + k) % 3;
            if (!found && r[idx]) begin
               found   = 1'b1;
               m_owner = idx + 1;
               m_held  = 1;
               m_last  = idx;
            end
         end
      end else if (!r[m_owner-1] || (m_held >= HOLD && !lk_eff)) begin
         m_owner = 0;
         m_done  = 1'b1;
      end else if (m_held < HOLD) begin
         m_held++;
      end
   endtask

   function automatic logic [6:0] dut_obs();
      return {sel3, sel2, sel1, gnt_id, busy, done};
   endfunction

   task automatic sb_check(input string tag);
      logic [6:0] exp;
      logic [6:0] obs;
      obs = dut_obs();
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb_q.pop_front();
         check(tag, {25'd0, obs}, {25'd0, exp});
      end
      check({tag, "_onehot"}, {31'd0, $onehot0({sel3, sel2, sel1})}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, {31'd0, gnt_id != 2'd0});
   endtask

   // One clock: drive, update model at the edge, compare #1 later.
   task automatic step(input string tag, input logic [2:0] r);
      req = r;
      @(posedge clock);
      m_edge(r, lock);
      sb_q.push_back(m_expect());
      #1;
      sb_check(tag);
   endtask

   // Asynchronous reset pulse taken mid-cycle; outputs must clear without a clock.
   task automatic pulse_reset(input string tag);
      resetn = 1'b0;
      #1;
      m_reset();
      sb_q.push_back(m_expect());
      sb_check(tag);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   logic [9:0] v_s1;
   logic [9:0] v_h1;
   logic       v_s23;
   int         run;
   int         ngrants;
   logic [1:0] order[4];
   logic       prev_busy;

   initial begin
      resetn = 1'b0;
      req    = 3'b111;
      lock   = 1'b0;
      m_reset();

      // Reset with all requests pending.
      #2;
      sb_q.push_back(m_expect());
      sb_check("reset_hold");
      @(posedge clock);
      #1;
      sb_q.push_back(m_expect());
      sb_check("reset_edge");
      @(negedge clock);
      resetn = 1'b1;
      step("first_grant", 3'b111);
      check("first_is_sel1", {31'd0, sel1}, 32'd1);

      // Single requester: 4-cycle grants with a 1-cycle gap.
      pulse_reset("rst_single");
      v_s23 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step("single", 3'b001);
         v_s1[i] = sel1;
         v_h1[i] = h1_sel1;
         v_s23   = v_s23 | sel2 | sel3;
      end
      check("single_sel1_pattern", {22'd0, v_s1}, {22'd0, 10'b0111101111});
      check("single_no_sel23", {31'd0, v_s23}, 32'd0);
      check("hold1_sel1_pattern", {22'd0, v_h1}, {22'd0, 10'b0101010101});
      // Request drop coinciding with expiry: single done pulse.
      step("coinc_grant", 3'b001);
      step("coinc_hold", 3'b001);
      step("coinc_hold", 3'b001);
      step("coinc_hold", 3'b001);
      step("coinc_end", 3'b000);
      check("coinc_done", {31'd0, done}, 32'd1);
      step("coinc_after", 3'b000);
      check("coinc_done_once", {31'd0, done}, 32'd0);

      // Round robin with all requesters active.
      pulse_reset("rst_rr");
      ngrants   = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step("rr", 3'b111);
         if (busy && !prev_busy && ngrants < 4) begin
            order[ngrants] = gnt_id;
            ngrants++;
         end
         prev_busy = busy;
      end
      check("rr_ngrants", ngrants, 4);
      check("rr_order0", {30'd0, order[0]}, 32'd1);
      check("rr_order1", {30'd0, order[1]}, 32'd2);
      check("rr_order2", {30'd0, order[2]}, 32'd3);
      check("rr_order3", {30'd0, order[3]}, 32'd1);

      // Early release after 2 cycles, then requester 3 is next.
      pulse_reset("rst_early");
      step("early_grant", 3'b010);
      check("early_sel2", {31'd0, sel2}, 32'd1);
      step("early_hold", 3'b010);
      check("early_sel2_2nd", {31'd0, sel2}, 32'd1);
      step("early_drop", 3'b000);
      check("early_end_sel2", {31'd0, sel2}, 32'd0);
      check("early_done", {31'd0, done}, 32'd1);
      step("early_next", 3'b100);
      check("early_next_sel3", {31'd0, sel3}, 32'd1);

      // Reset mid-grant, then priority returns to requester 1.
      pulse_reset("rst_mid_pre");
      step("mid_grant", 3'b010);
      step("mid_hold", 3'b010);
      #2;
      pulse_reset("rst_mid");
      check("mid_sel2_clear", {31'd0, sel2}, 32'd0);
      step("mid_after", 3'b111);
      check("mid_after_sel1", {31'd0, sel1}, 32'd1);

      // Lock: requester 2 with lock high for 10 edges, then lock low.
      pulse_reset("rst_lock");
      lock = 1'b1;
      run  = 0;
      for (int i = 0; i < 10; i++) begin
         step("lock_on", 3'b010);
         if (sel2 && run == i) run++;
      end
      lock = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step("lock_off", 3'b010);
      end
`ifdef MUX_ARB_LOCK_EN
      check("lock_run", run, 10);
`else
      check("lock_run", run, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
